// File: rtl/cond_status_unit.sv
// cond_status_unit
//
// Holds the architectural NZCV status register written back by the EXE-stage
// ALU, evaluates the condition field of the instruction in ID against those
// flags, and registers the pass/fail verdict into the ID/EXE boundary where it
// gates register and flag write-back. A flag-setting instruction in EXE
// followed by a conditional instruction in ID is resolved either by bypassing
// the EXE flags into the ID evaluation or by stalling ID for one cycle.
//
// Build option:
//   FLAG_FORWARD_EN  defined   -> EXE flags are bypassed into ID evaluation,
//                                 id_stall is tied low.
//                    undefined -> no bypass; id_stall is raised for one cycle
//                                 per hazard and ID evaluates from status_q.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   freeze         in   pipeline freeze, holds all state
//   flush          in   branch-taken flush of the ID instruction
//   exe_valid      in   EXE holds a live instruction
//   exe_s          in   EXE instruction updates the flags
//   exe_cond_ok    in   EXE instruction passed its condition
//   exe_status     in   ALU status bits {n,z,c,v}
//   id_valid       in   ID holds a live instruction
//   id_cond        in   condition field of the ID instruction
//   status_q       out  architectural flags {n,z,c,v}
//   id_stall       out  stall request to IF/ID (combinational)
//   exe_cond_pass  out  registered verdict for the instruction now in EXE

module cond_status_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       freeze,
    input  logic       flush,
    input  logic       exe_valid,
    input  logic       exe_s,
    input  logic       exe_cond_ok,
    input  logic [3:0] exe_status,
    input  logic       id_valid,
    input  logic [3:0] id_cond,
    output logic [3:0] status_q,
    output logic       id_stall,
    output logic       exe_cond_pass
);

    localparam int LEN_STATUS = 4;

    localparam logic [3:0] COND_AL = 4'hE;

    logic                  flag_write;
    logic                  hz;
    logic [LEN_STATUS-1:0] flags_eval;
    logic                  cond_ok_id;
    logic                  bubble;

    // Condition decode; flag order is {n,z,c,v}. Carry is taken as the ALU
    // produces it, with no borrow inversion.
    function automatic logic cond_pass(input logic [3:0] cond,
                                       input logic [LEN_STATUS-1:0] flags);
        logic n, z, c, v;
        logic result;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        result = 1'b0;
        case (cond)
            4'h0:    result = z;
            4'h1:    result = !z;
            4'h2:    result = c;
            4'h3:    result = !c;
            4'h4:    result = n;
            4'h5:    result = !n;
            4'h6:    result = v;
            4'h7:    result = !v;
            4'h8:    result = c && !z;
            4'h9:    result = !c || z;
            4'hA:    result = (n == v);
            4'hB:    result = (n != v);
            4'hC:    result = !z && (n == v);
            4'hD:    result = z || (n != v);
            4'hE:    result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    // Only a live, flag-setting instruction that passed its own condition
    // changes the flags.
    assign flag_write = exe_valid && exe_s && exe_cond_ok;

    // AL does not read the flags, so it never creates a hazard.
    assign hz = flag_write && id_valid && (id_cond != COND_AL);

`ifdef FLAG_FORWARD_EN
    assign flags_eval = hz ? exe_status : status_q;
    assign id_stall   = 1'b0;
`else
    // Flush wins over stall: a flushed instruction never needs the flags.
    assign flags_eval = status_q;
    assign id_stall   = hz && !flush;
`endif

    assign cond_ok_id = cond_pass(id_cond, flags_eval);

    // A stalled ID instruction is re-presented next cycle, so the slot it
    // would have filled in EXE becomes a bubble.
    assign bubble = flush || id_stall || !id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
        end else if (!freeze && flag_write) begin
            status_q <= exe_status;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_cond_pass <= 1'b0;
        end else if (!freeze) begin
            exe_cond_pass <= bubble ? 1'b0 : cond_ok_id;
        end
    end

endmodule

// File: tb/tb_cond_status_unit.sv
module tb_cond_status_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       freeze, flush, exe_valid, exe_s, exe_cond_ok, id_valid;
    logic [3:0] exe_status, id_cond;
    logic [3:0] status_q;
    logic       id_stall, exe_cond_pass;

    cond_status_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .freeze       (freeze),
        .flush        (flush),
        .exe_valid    (exe_valid),
        .exe_s        (exe_s),
        .exe_cond_ok  (exe_cond_ok),
        .exe_status   (exe_status),
        .id_valid     (id_valid),
        .id_cond      (id_cond),
        .status_q     (status_q),
        .id_stall     (id_stall),
        .exe_cond_pass(exe_cond_pass)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int K_PASS   = 0;
    localparam int K_STATUS = 1;
    localparam int K_STALL  = 2;

    typedef struct {
        int         due;
        int         kind;
        logic [3:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push(input int due, input int kind, input logic [3:0] e, input string name);
        exp_t x;
        x.due  = due;
        x.kind = kind;
        x.exp  = e;
        x.name = name;
        sb.push_back(x);
    endtask

    // Reference: base predicate per condition pair, odd codes invert it.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] nzcv);
        logic n, z, cf, v, base;
        n  = nzcv[3];
        z  = nzcv[2];
        cf = nzcv[1];
        v  = nzcv[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = ~(n ^ v);
            3'd6: base = ~z & ~(n ^ v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    // Monitor: every falling edge, compare all expectations due this cycle.
    always @(negedge clk) begin
        logic [3:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                case (sb[i].kind)
                    K_PASS:   act = {3'b000, exe_cond_pass};
                    K_STATUS: act = status_q;
                    default:  act = {3'b000, id_stall};
                endcase
                n_cmp++;
                if (act !== sb[i].exp) begin
                    n_bad++;
                    $display("FAIL %s (cycle %0d): got %h, expected %h",
                             sb[i].name, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic drive(input logic fz, input logic fl, input logic ev, input logic es,
                         input logic eok, input logic [3:0] est, input logic iv,
                         input logic [3:0] ic);
        @(posedge clk);
        #1;
        freeze      = fz;
        flush       = fl;
        exe_valid   = ev;
        exe_s       = es;
        exe_cond_ok = eok;
        exe_status  = est;
        id_valid    = iv;
        id_cond     = ic;
    endtask

    // Write flags through a live flag-setter with ID empty.
    task automatic load(input logic [3:0] s);
        drive(0, 0, 1, 1, 1, s, 0, 4'h0);
        push(cyc + 1, K_STATUS, s, "load_status");
        push(cyc + 1, K_PASS, 4'h0, "load_bubble");
    endtask

    task automatic eval(input logic [3:0] c, input logic e, input string name);
        drive(0, 0, 0, 0, 0, 4'h0, 1, c);
        push(cyc, K_STALL, 4'h0, {name, "_stall"});
        push(cyc + 1, K_PASS, {3'b000, e}, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        freeze = 0; flush = 0; exe_valid = 0; exe_s = 0; exe_cond_ok = 0;
        exe_status = 4'h0; id_valid = 0; id_cond = 4'h0;
        push(1, K_STATUS, 4'h0, "reset_status");
        push(1, K_PASS,   4'h0, "reset_pass");
        push(1, K_STALL,  4'h0, "reset_stall");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Full decode sweep against the reference predicate.
        for (int s = 0; s < 16; s++) begin
            load(4'(s));
            for (int c = 0; c < 16; c++)
                eval(4'(c), ref_pass(4'(c), 4'(s)), $sformatf("decode_s%h_c%h", s, c));
        end

        // Hand-computed spot checks.
        load(4'b1001);
        eval(4'hA, 1'b1, "spot_ge_1001");
        load(4'b0100);
        eval(4'hC, 1'b0, "spot_gt_0100");
        load(4'b1111);
        eval(4'hF, 1'b0, "spot_nv_1111");
        eval(4'hE, 1'b1, "spot_al_1111");

        // Flag hazard: CMP in EXE producing Z, EQ in ID.
        load(4'b0000);
        drive(0, 0, 1, 1, 1, 4'b0100, 1, 4'h0);
        push(cyc + 1, K_STATUS, 4'b0100, "hz_status");
`ifdef FLAG_FORWARD_EN
        push(cyc,     K_STALL, 4'h0, "hz_fwd_stall");
        push(cyc + 1, K_PASS,  4'h1, "hz_fwd_pass");
`else
        push(cyc,     K_STALL, 4'h1, "hz_nofwd_stall");
        push(cyc + 1, K_PASS,  4'h0, "hz_nofwd_bubble");
        drive(0, 0, 0, 0, 0, 4'h0, 1, 4'h0);
        push(cyc,     K_STALL, 4'h0, "hz_nofwd_stall_drop");
        push(cyc + 1, K_PASS,  4'h1, "hz_nofwd_pass");
`endif

        // AL in ID alongside a flag setter is not a hazard.
        drive(0, 0, 1, 1, 1, 4'b0000, 1, 4'hE);
        push(cyc,     K_STALL,  4'h0,    "hz_al_stall");
        push(cyc + 1, K_PASS,   4'h1,    "hz_al_pass");
        push(cyc + 1, K_STATUS, 4'b0000, "hz_al_status");

        // Freeze holds both registers.
        load(4'b0101);
        eval(4'h0, 1'b1, "pre_freeze_eq");
        drive(1, 0, 1, 1, 1, 4'b1111, 0, 4'h0);
        push(cyc + 1, K_STATUS, 4'b0101, "freeze_status");
        push(cyc + 1, K_PASS,   4'h1,    "freeze_pass");
        eval(4'h1, 1'b0, "post_freeze_ne");

        // Flush: no stall, bubble verdict.
        drive(0, 1, 0, 0, 0, 4'h0, 1, 4'hE);
        push(cyc,     K_STALL, 4'h0, "flush_al_stall");
        push(cyc + 1, K_PASS,  4'h0, "flush_al_pass");
        drive(0, 1, 1, 1, 1, 4'b0000, 1, 4'h0);
        push(cyc,     K_STALL,  4'h0,    "flush_hz_stall");
        push(cyc + 1, K_PASS,   4'h0,    "flush_hz_pass");
        push(cyc + 1, K_STATUS, 4'b0000, "flush_hz_status");

        // Flag setter that failed its condition writes nothing.
        drive(0, 0, 1, 1, 0, 4'b0010, 1, 4'h2);
        push(cyc,     K_STALL,  4'h0,    "failset_stall");
        push(cyc + 1, K_PASS,   4'h0,    "failset_pass");
        push(cyc + 1, K_STATUS, 4'b0000, "failset_status");
        eval(4'h2, 1'b0, "failset_cs_after");
        drive(0, 0, 0, 1, 1, 4'b1111, 0, 4'h0);
        push(cyc + 1, K_STATUS, 4'b0000, "invalid_exe_status");

        // Asynchronous reset mid-run.
        drive(0, 0, 1, 1, 1, 4'b1010, 1, 4'hE);
        push(cyc + 1, K_PASS, 4'h1, "prereset_pass");
        drive(0, 0, 0, 0, 0, 4'h0, 1, 4'hE);
        push(cyc, K_STATUS, 4'b1010, "prereset_status");
        @(posedge clk);
        #1 rst_n = 1'b0;
        push(cyc, K_STATUS, 4'h0, "async_reset_status");
        push(cyc, K_PASS,   4'h0, "async_reset_pass");
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 4'h0, 0, 4'h0);
        drive(0, 0, 0, 0, 0, 4'h0, 0, 4'h0);
        @(posedge clk);
        #1;

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
